// File: rtl/reg_file_arb.sv
// Purpose: UART-side register file (cmd strobe @0, RW control, RO status) shared by two masters via a round-robin req/gnt arbiter.
// Latency: grant 1 cycle after req sampled in IDLE; write visible and read data valid 1 cycle after the qualified access.
// Backpressure: a master may only access while its gnt is high; ownership is non-preemptive with at least one IDLE cycle between owners.
module reg_file_arb #(
    parameter int NUM_REGS = 16,
    parameter int RO_BASE  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    // master 0: UART parser
    input  logic                              m0_req_i,
    output logic                              m0_gnt_o,
    input  logic [7:0]                        m0_addr_i,
    input  logic                              m0_wen_i,
    input  logic [7:0]                        m0_wdata_i,
    input  logic                              m0_ren_i,
    output logic [7:0]                        m0_rdata_o,
    // master 1: local control logic
    input  logic                              m1_req_i,
    output logic                              m1_gnt_o,
    input  logic [7:0]                        m1_addr_i,
    input  logic                              m1_wen_i,
    input  logic [7:0]                        m1_wdata_i,
    input  logic                              m1_ren_i,
    output logic [7:0]                        m1_rdata_o,
    // register file side
    output logic [8*RO_BASE-1:0]              ctrl_o,
    input  logic [8*(NUM_REGS-RO_BASE)-1:0]   status_i,
    output logic [7:0]                        cmd_o,
    output logic                              cmd_stb_o
);

    localparam int NUM_STATUS = NUM_REGS - RO_BASE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // One bus access as seen by the register file after grant qualification.
    typedef struct packed {
        logic [7:0] addr;
        logic       wen;
        logic [7:0] wdata;
        logic       ren;
    } bus_acc_t;

    arb_state_e state_q;
    logic       gnt0_q;
    logic       gnt1_q;
    logic       last_m1_q;      // 1: m1 was served last, so m0 wins a tie

    bus_acc_t   acc;
    logic [7:0] rd_val_d;

    logic [7:0] ctrl_q [RO_BASE];   // entry 0 is never written and reads as 0
    logic [7:0] cmd_q;
    logic       cmd_stb_q;
    logic [7:0] rdata0_q;
    logic [7:0] rdata1_q;

    // Round-robin arbiter: non-preemptive ownership, registered grants, IDLE gap between owners.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            last_m1_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_req_i && (!m1_req_i || last_m1_q)) begin
                        state_q <= OWN0;
                        gnt0_q  <= 1'b1;
                    end else if (m1_req_i) begin
                        state_q <= OWN1;
                        gnt1_q  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!m0_req_i) begin
                        state_q   <= IDLE;
                        gnt0_q    <= 1'b0;
                        last_m1_q <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1_req_i) begin
                        state_q   <= IDLE;
                        gnt1_q    <= 1'b0;
                        last_m1_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pass through only the granted master's strobes; an ungranted master is invisible.
    always_comb begin
        acc = '0;
        if (gnt0_q) begin
            acc = '{addr: m0_addr_i, wen: m0_wen_i, wdata: m0_wdata_i, ren: m0_ren_i};
        end else if (gnt1_q) begin
            acc = '{addr: m1_addr_i, wen: m1_wen_i, wdata: m1_wdata_i, ren: m1_ren_i};
        end
    end

    // Read decode on the full 8-bit address; unmapped and address 0 read as zero.
    always_comb begin
        rd_val_d = 8'h00;
        for (int k = 1; k < RO_BASE; k++) begin
            if (acc.addr == 8'(k)) rd_val_d = ctrl_q[k];
        end
        for (int j = 0; j < NUM_STATUS; j++) begin
            if (acc.addr == 8'(RO_BASE + j)) rd_val_d = status_i[8*j +: 8];
        end
    end

    // Register writes, command strobe and per-master read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RO_BASE; k++) ctrl_q[k] <= 8'h00;
            cmd_q     <= 8'h00;
            cmd_stb_q <= 1'b0;
            rdata0_q  <= 8'h00;
            rdata1_q  <= 8'h00;
        end else begin
            cmd_stb_q <= acc.wen && (acc.addr == 8'h00);
            if (acc.wen && (acc.addr == 8'h00)) cmd_q <= acc.wdata;
            for (int k = 1; k < RO_BASE; k++) begin
                if (acc.wen && (acc.addr == 8'(k))) ctrl_q[k] <= acc.wdata;
            end
            // read value is taken before this edge's write lands, so wen+ren returns the old value
            if (acc.ren && gnt0_q) rdata0_q <= rd_val_d;
            if (acc.ren && gnt1_q) rdata1_q <= rd_val_d;
        end
    end

    assign ctrl_o[7:0] = 8'h00;
    for (genvar g = 1; g < RO_BASE; g++) begin : g_ctrl
        assign ctrl_o[8*g +: 8] = ctrl_q[g];
    end

    assign m0_gnt_o   = gnt0_q;
    assign m1_gnt_o   = gnt1_q;
    assign m0_rdata_o = rdata0_q;
    assign m1_rdata_o = rdata1_q;
    assign cmd_o      = cmd_q;
    assign cmd_stb_o  = cmd_stb_q;

endmodule

// File: tb/tb_reg_file_arb.sv
// Purpose: directed self-checking bench for reg_file_arb (arbitration, writes, reads, strobes, reset).
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns after the following edge.
// Backpressure: bench drives accesses only while the relevant grant is expected high.
module tb_reg_file_arb;

    logic        clk;
    logic        rst;
    logic        m0_req_i, m0_wen_i, m0_ren_i;
    logic [7:0]  m0_addr_i, m0_wdata_i;
    logic        m0_gnt_o;
    logic [7:0]  m0_rdata_o;
    logic        m1_req_i, m1_wen_i, m1_ren_i;
    logic [7:0]  m1_addr_i, m1_wdata_i;
    logic        m1_gnt_o;
    logic [7:0]  m1_rdata_o;
    logic [63:0] ctrl_o;
    logic [63:0] status_i;
    logic [7:0]  cmd_o;
    logic        cmd_stb_o;

    int vectors;
    int miscompares;

    reg_file_arb #(.NUM_REGS(16), .RO_BASE(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req_i   (m0_req_i),
        .m0_gnt_o   (m0_gnt_o),
        .m0_addr_i  (m0_addr_i),
        .m0_wen_i   (m0_wen_i),
        .m0_wdata_i (m0_wdata_i),
        .m0_ren_i   (m0_ren_i),
        .m0_rdata_o (m0_rdata_o),
        .m1_req_i   (m1_req_i),
        .m1_gnt_o   (m1_gnt_o),
        .m1_addr_i  (m1_addr_i),
        .m1_wen_i   (m1_wen_i),
        .m1_wdata_i (m1_wdata_i),
        .m1_ren_i   (m1_ren_i),
        .m1_rdata_o (m1_rdata_o),
        .ctrl_o     (ctrl_o),
        .status_i   (status_i),
        .cmd_o      (cmd_o),
        .cmd_stb_o  (cmd_stb_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_idle();
        m0_wen_i = 1'b0; m0_ren_i = 1'b0; m0_addr_i = 8'h00; m0_wdata_i = 8'h00;
    endtask

    task automatic m1_idle();
        m1_wen_i = 1'b0; m1_ren_i = 1'b0; m1_addr_i = 8'h00; m1_wdata_i = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gnt: got %b%b want 00", m0_gnt_o, m1_gnt_o);
        end
        vectors++;
        if (ctrl_o !== 64'h0 || cmd_o !== 8'h00 || cmd_stb_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_regs: got ctrl=%h cmd=%h stb=%b want 0/00/0", ctrl_o, cmd_o, cmd_stb_o);
        end
        vectors++;
        if (m0_rdata_o !== 8'h00 || m1_rdata_o !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h/%h want 00/00", m0_rdata_o, m1_rdata_o);
        end
    endtask

    task automatic test_basic_rw();
        m0_req_i = 1'b1;
        tick();
        vectors++;
        if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_gnt: got %b%b want 10", m0_gnt_o, m1_gnt_o);
        end
        m0_wen_i = 1'b1; m0_addr_i = 8'h03; m0_wdata_i = 8'h5A;
        tick();
        vectors++;
        if (ctrl_o[31:24] !== 8'h5A) begin
            miscompares++;
            $display("FAIL basic_write3: got %h want 5a", ctrl_o[31:24]);
        end
        m0_idle();
        m0_ren_i = 1'b1; m0_addr_i = 8'h03;
        tick();
        m0_idle();
        vectors++;
        if (m0_rdata_o !== 8'h5A) begin
            miscompares++;
            $display("FAIL basic_read3: got %h want 5a", m0_rdata_o);
        end
        m0_req_i = 1'b0;
        tick();
        vectors++;
        if (m0_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_release: got %b want 0", m0_gnt_o);
        end
    endtask

    task automatic test_arbitration();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        tick();
        vectors++;
        if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_tie_after_reset: got %b%b want 10", m0_gnt_o, m1_gnt_o);
        end
        tick();
        vectors++;
        if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_no_preempt: got %b%b want 10", m0_gnt_o, m1_gnt_o);
        end
        m0_req_i = 1'b0;
        tick();
        vectors++;
        if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_idle_gap: got %b%b want 00", m0_gnt_o, m1_gnt_o);
        end
        tick();
        vectors++;
        if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b1) begin
            miscompares++;
            $display("FAIL arb_m1_grant: got %b%b want 01", m0_gnt_o, m1_gnt_o);
        end
        m1_req_i = 1'b0;
        tick();
        vectors++;
        if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_m1_release: got %b%b want 00", m0_gnt_o, m1_gnt_o);
        end
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        tick();
        vectors++;
        if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_round_robin: got %b%b want 10", m0_gnt_o, m1_gnt_o);
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        tick();
    endtask

    task automatic test_isolation();
        m0_req_i = 1'b1;
        tick();
        m0_wen_i = 1'b1; m0_addr_i = 8'h02; m0_wdata_i = 8'h11;
        tick();
        m0_idle();
        m1_req_i = 1'b1; m1_wen_i = 1'b1; m1_ren_i = 1'b1; m1_addr_i = 8'h02; m1_wdata_i = 8'hFF;
        tick();
        vectors++;
        if (ctrl_o[23:16] !== 8'h11) begin
            miscompares++;
            $display("FAIL iso_ignored_write: got %h want 11", ctrl_o[23:16]);
        end
        vectors++;
        if (m1_rdata_o !== 8'h00 || m1_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL iso_ignored_read: got rdata=%h gnt=%b want 00/0", m1_rdata_o, m1_gnt_o);
        end
        m1_req_i = 1'b0;
        m1_idle();
        m0_ren_i = 1'b1; m0_addr_i = 8'h02;
        tick();
        m0_idle();
        vectors++;
        if (m0_rdata_o !== 8'h11) begin
            miscompares++;
            $display("FAIL iso_read2: got %h want 11", m0_rdata_o);
        end
    endtask

    task automatic test_cmd_strobe();
        m0_wen_i = 1'b1; m0_addr_i = 8'h00; m0_wdata_i = 8'hA5;
        tick();
        vectors++;
        if (cmd_stb_o !== 1'b1 || cmd_o !== 8'hA5) begin
            miscompares++;
            $display("FAIL cmd_first: got stb=%b cmd=%h want 1/a5", cmd_stb_o, cmd_o);
        end
        tick();
        m0_idle();
        vectors++;
        if (cmd_stb_o !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_second: got stb=%b want 1", cmd_stb_o);
        end
        m0_ren_i = 1'b1; m0_addr_i = 8'h00;
        tick();
        m0_idle();
        vectors++;
        if (cmd_stb_o !== 1'b0 || cmd_o !== 8'hA5) begin
            miscompares++;
            $display("FAIL cmd_stb_end: got stb=%b cmd=%h want 0/a5", cmd_stb_o, cmd_o);
        end
        vectors++;
        if (m0_rdata_o !== 8'h00) begin
            miscompares++;
            $display("FAIL cmd_read0: got %h want 00", m0_rdata_o);
        end
        vectors++;
        if (ctrl_o !== 64'h0000_0000_0011_0000) begin
            miscompares++;
            $display("FAIL cmd_ctrl_untouched: got %h want 0000000000110000", ctrl_o);
        end
    endtask

    task automatic test_status();
        status_i = 64'hE700_0000_0000_003C;
        m0_ren_i = 1'b1; m0_addr_i = 8'h08;
        tick();
        m0_idle();
        vectors++;
        if (m0_rdata_o !== 8'h3C) begin
            miscompares++;
            $display("FAIL status_read8: got %h want 3c", m0_rdata_o);
        end
        m0_wen_i = 1'b1; m0_addr_i = 8'h08; m0_wdata_i = 8'h00;
        tick();
        m0_idle();
        m0_ren_i = 1'b1; m0_addr_i = 8'h08;
        tick();
        m0_idle();
        vectors++;
        if (m0_rdata_o !== 8'h3C) begin
            miscompares++;
            $display("FAIL status_ro_write: got %h want 3c", m0_rdata_o);
        end
        m0_ren_i = 1'b1; m0_addr_i = 8'h0F;
        tick();
        m0_idle();
        vectors++;
        if (m0_rdata_o !== 8'hE7) begin
            miscompares++;
            $display("FAIL status_read15: got %h want e7", m0_rdata_o);
        end
        m0_ren_i = 1'b1; m0_addr_i = 8'h20;
        tick();
        m0_idle();
        vectors++;
        if (m0_rdata_o !== 8'h00) begin
            miscompares++;
            $display("FAIL status_read20: got %h want 00", m0_rdata_o);
        end
        m0_wen_i = 1'b1; m0_addr_i = 8'h20; m0_wdata_i = 8'h99;
        tick();
        m0_wen_i = 1'b1; m0_addr_i = 8'h13; m0_wdata_i = 8'hEE;
        tick();
        m0_wen_i = 1'b1; m0_addr_i = 8'h07; m0_wdata_i = 8'h7F;
        tick();
        m0_idle();
        vectors++;
        if (ctrl_o !== 64'h7F00_0000_0011_0000) begin
            miscompares++;
            $display("FAIL status_unmapped_writes: got %h want 7f00000000110000", ctrl_o);
        end
        m0_ren_i = 1'b1; m0_addr_i = 8'h07;
        tick();
        m0_ren_i = 1'b1; m0_addr_i = 8'h17;
        tick();
        m0_idle();
        vectors++;
        if (m0_rdata_o !== 8'h00) begin
            miscompares++;
            $display("FAIL status_no_alias: got %h want 00", m0_rdata_o);
        end
        m0_wen_i = 1'b1; m0_ren_i = 1'b1; m0_addr_i = 8'h07; m0_wdata_i = 8'h55;
        tick();
        m0_idle();
        vectors++;
        if (m0_rdata_o !== 8'h7F || ctrl_o[63:56] !== 8'h55) begin
            miscompares++;
            $display("FAIL rw_same_cycle: got rdata=%h ctrl7=%h want 7f/55", m0_rdata_o, ctrl_o[63:56]);
        end
    endtask

    task automatic test_reset_mid();
        m0_req_i = 1'b0;
        tick();
        m1_req_i = 1'b1;
        tick();
        vectors++;
        if (m1_gnt_o !== 1'b1 || m0_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_m1_owns: got %b%b want 01", m0_gnt_o, m1_gnt_o);
        end
        m1_ren_i = 1'b1; m1_addr_i = 8'h02;
        tick();
        vectors++;
        if (m1_rdata_o !== 8'h11 || m0_rdata_o !== 8'h7F) begin
            miscompares++;
            $display("FAIL mid_m1_read: got m1=%h m0=%h want 11/7f", m1_rdata_o, m0_rdata_o);
        end
        m1_addr_i = 8'h07;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m1_idle();
        vectors++;
        if (m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0 || ctrl_o !== 64'h0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got gnt=%b%b ctrl=%h want 00/0", m0_gnt_o, m1_gnt_o, ctrl_o);
        end
        vectors++;
        if (m0_rdata_o !== 8'h00 || m1_rdata_o !== 8'h00 || cmd_o !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_rdata: got m0=%h m1=%h cmd=%h want 00/00/00", m0_rdata_o, m1_rdata_o, cmd_o);
        end
        m0_req_i = 1'b1;
        tick();
        vectors++;
        if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_rr: got %b%b want 10", m0_gnt_o, m1_gnt_o);
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        m0_idle();
        m1_idle();
        status_i = 64'h0;
        test_reset();
        test_basic_rw();
        test_arbitration();
        test_isolation();
        test_cmd_strobe();
        test_status();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_arb.md
Name: reg_file_arb

Overview:
- Register file on the UART block's internal bus, directly downstream of the UART parser.
- Two bus masters share it through a round-robin req/gnt arbiter:
  - master 0: the UART parser (addr/wen/wdata/ren/rdata/req/gnt);
  - master 1: local control logic.
- It holds writable control registers, exposes read-only status inputs, and provides a one-shot command strobe register at address 0.

Parameters:
- NUM_REGS, 16: number of decoded 8-bit addresses, 0..NUM_REGS-1.
- RO_BASE, 8: addresses RO_BASE..NUM_REGS-1 are read-only status; 1..RO_BASE-1 are read/write control.

Ports:
- clk  in  1  global clock.
- rst  in  1  global reset; synchronous, active-high.
- Master 0 (UART parser):
  - m0_req_i  in  1  bus request.
  - m0_gnt_o  out  1  bus grant.
  - m0_addr_i  in  8  address.
  - m0_wen_i  in  1  write enable.
  - m0_wdata_i  in  8  write data.
  - m0_ren_i  in  1  read enable.
  - m0_rdata_o  out  8  read data.
- m1_req_i, m1_gnt_o, m1_addr_i, m1_wen_i, m1_wdata_i, m1_ren_i, m1_rdata_o: same as the m0_* ports, for master 1 (local logic).
- ctrl_o  out  8*RO_BASE  control register contents; byte k = register k; byte 0 is always 0x00.
- status_i  in  8*(NUM_REGS-RO_BASE)  status inputs; byte j is read at address RO_BASE+j.
- cmd_o  out  8  command byte from the last write to address 0.
- cmd_stb_o  out  1  one-cycle strobe on a write to address 0.

Behaviour:
- Reset: one clock with rst high sets all of the following; applies equally mid-transaction, and an in-flight read returns nothing.
  - gnt 0; arbiter IDLE; RR pointer favours m0.
  - All control registers, both rdata, cmd_o and cmd_stb_o are 0x00/0.
- Arbiter FSM, states IDLE, OWN0, OWN1. Grants are registered.
  - IDLE, one requester: the next state is that master's OWN state; its gnt goes high the cycle after req is sampled.
  - IDLE, both requesting: the master not served last wins; after reset, m0 wins.
  - OWNx: grant held while reqx stays high; the other master's req is ignored, no preemption.
  - OWNx with reqx low at a clock edge: goes to IDLE and gnt drops the next cycle. Same-edge handover is not allowed, so there is at least one IDLE cycle between owners.
  - After releasing OWNx, the pointer records x as last served.
  - gnt is never high for both masters at once.
- Access qualification: wen/ren/addr/wdata are used only from the master whose gnt is high in that cycle. Strobes from a non-granted master are ignored.
- Write, on an edge with wen && gnt:
  - addr 0: cmd_o <= wdata; cmd_stb_o = 1 for exactly the next cycle. Back-to-back writes give consecutive strobes.
  - 1..RO_BASE-1: register updated; the new value appears on ctrl_o the next cycle.
  - RO_BASE and above, including addr >= NUM_REGS: write silently ignored.
- Read, ren && gnt in cycle N: the granted master's rdata_o is valid from cycle N+1 and holds until that master's next qualified read.
  - addr 0 returns 0x00.
  - Control addresses return the register value.
  - Status addresses return status_i sampled in cycle N.
  - addr >= NUM_REGS returns 0x00.
- wen and ren in the same cycle: the write is performed and the read returns the pre-write value.
- The other master's rdata_o is unchanged during any access.
- Address is the full 8 bits with no aliasing: addr NUM_REGS+k does not map to k.

Test Plan:
- Reset, then m0 req high at cycle 0 -> m0_gnt_o high at cycle 1. m0 writes 0x5A to addr 3 -> ctrl_o byte 3 = 0x5A the next cycle. m0 reads addr 3 -> m0_rdata_o = 0x5A one cycle later.
- Both req high from IDLE after reset -> m0 granted. m0 drops req -> one IDLE cycle, then m1 granted. Both request again after m1 releases -> m0 granted (round robin). Check gnt never high for both.
- m1 (not granted) drives wen to addr 2 with 0xFF while m0 owns the bus -> register 2 unchanged. m0 reads addr 2 -> old value.
- m0 writes 0xA5 to addr 0 twice back-to-back -> cmd_o = 0xA5, cmd_stb_o high for exactly 2 cycles. Read addr 0 -> 0x00.
- status_i byte 0 = 0x3C: read addr RO_BASE -> 0x3C. Write 0x00 to addr RO_BASE, then re-read -> still 0x3C. Read addr 0x20 -> 0x00. Write to 0x20 -> no ctrl_o change.
- Assert rst for one cycle while m1 owns the bus with a read in flight -> next cycle both gnt 0, ctrl_o all 0, rdata 0. Then both request -> m0 granted.
